// File: rtl/fifo_unpacker.sv
// Drains a show-ahead FIFO one word at a time and streams each word as CHUNK-bit beats.
// Optional: define UNPACK_MSB_FIRST_EN to emit the most-significant chunk first.
module fifo_unpacker #(
   parameter int BITSIZE = 44,
   parameter int CHUNK   = 11
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [BITSIZE-1:0] fifo_data,
   input  logic               fifo_emptyp,
   output logic               fifo_readp,
   output logic [CHUNK-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic [15:0]        word_count
);
   localparam int BEATS = BITSIZE / CHUNK;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state, state_next;
   logic [BITSIZE-1:0] sreg, sreg_next, sreg_shifted;
   logic [CW-1:0]      beat_cnt, beat_next;
   logic [15:0]        count_next;
   logic [CHUNK-1:0]   head_chunk;
   logic               pop;

`ifdef UNPACK_MSB_FIRST_EN
   assign head_chunk   = sreg[BITSIZE-1 -: CHUNK];
   assign sreg_shifted = sreg << CHUNK;
`else
   assign head_chunk   = sreg[CHUNK-1:0];
   assign sreg_shifted = sreg >> CHUNK;
`endif

   always_comb begin
      state_next = state;
      sreg_next  = sreg;
      beat_next  = beat_cnt;
      count_next = word_count;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_emptyp) begin
               pop        = 1'b1;
               sreg_next  = fifo_data;
               beat_next  = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (beat_cnt != LAST_BEAT) begin
                  sreg_next = sreg_shifted;
                  beat_next = beat_cnt + CW'(1);
               end else begin
                  count_next = word_count + 16'd1;
                  // Reload straight from the FIFO head so consecutive words have no bubble.
                  if (!fifo_emptyp) begin
                     pop       = 1'b1;
                     sreg_next = fifo_data;
                     beat_next = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         sreg       <= '0;
         beat_cnt   <= '0;
         word_count <= '0;
      end else begin
         state      <= state_next;
         sreg       <= sreg_next;
         beat_cnt   <= beat_next;
         word_count <= count_next;
      end
   end

   assign out_valid  = (state == SEND);
   assign busy       = out_valid;
   assign out_data   = out_valid ? head_chunk : '0;
   assign out_last   = out_valid && (beat_cnt == LAST_BEAT);
   assign fifo_readp = pop & rstn;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker: queue-based FIFO and beat-stream model, directed and random traffic.
module tb_fifo_unpacker;
   localparam int BITSIZE = 44;
   localparam int CHUNK   = 11;
   localparam int BEATS   = BITSIZE / CHUNK;

   logic               clk = 1'b0;
   logic               rstn;
   logic [BITSIZE-1:0] fifo_data;
   logic               fifo_emptyp;
   logic               fifo_readp;
   logic [CHUNK-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic               busy;
   logic [15:0]        word_count;

   fifo_unpacker #(.BITSIZE(BITSIZE), .CHUNK(CHUNK)) dut (
      .clk(clk), .rstn(rstn), .fifo_data(fifo_data), .fifo_emptyp(fifo_emptyp),
      .fifo_readp(fifo_readp), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [CHUNK-1:0] d; logic last;} hs_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [BITSIZE-1:0] q[$];
   logic [CHUNK-1:0]   exp_beats[$];
   logic [15:0]        m_count = '0;
   logic               pop_seen = 1'b0;
   hs_t                hs_log[$];
   int                 pop_log[$];

   logic [BITSIZE-1:0] W1 = {11'h7FF, 11'h001, 11'h155, 11'h2AA};
   logic [CHUNK-1:0]   lit[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CHUNK-1:0] beat_of(input logic [BITSIZE-1:0] w, input int i);
`ifdef UNPACK_MSB_FIRST_EN
      return w[BITSIZE-1-i*CHUNK -: CHUNK];
`else
      return w[i*CHUNK +: CHUNK];
`endif
   endfunction

   // Per-cycle compare against the beat-queue model.
   always @(negedge clk) begin
      logic             e_valid, e_last, e_pop;
      logic [CHUNK-1:0] e_data;
      cyc++;
      if (!rstn) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_last", out_last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_readp", fifo_readp, 0);
         chk("rst_count", word_count, 0);
         exp_beats.delete();
         m_count  = '0;
         pop_seen = 1'b0;
      end else begin
         e_valid = exp_beats.size() > 0;
         e_data  = e_valid ? exp_beats[0] : '0;
         e_last  = e_valid && exp_beats.size() == 1;
         e_pop   = (q.size() > 0) && (!e_valid || (exp_beats.size() == 1 && out_ready));
         chk("valid", out_valid, e_valid);
         chk("busy", busy, e_valid);
         chk("data", out_data, e_data);
         chk("last", out_last, e_last);
         chk("readp", fifo_readp, e_pop);
         chk("word_count", word_count, m_count);
         if (fifo_readp) pop_log.push_back(cyc);
         if (out_valid && out_ready) hs_log.push_back('{cyc, out_data, out_last});
         if (e_valid && out_ready) begin
            void'(exp_beats.pop_front());
            if (e_last) m_count++;
         end
         if (e_pop) for (int i = 0; i < BEATS; i++) exp_beats.push_back(beat_of(q[0], i));
         pop_seen = fifo_readp;
      end
   end

   task automatic drive_fifo();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      fifo_emptyp = (q.size() == 0);
      fifo_data   = (q.size() > 0) ? q[0] : r[BITSIZE-1:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pop_seen) begin
         if (q.size() > 0) void'(q.pop_front());
         pop_seen = 1'b0;
      end
      drive_fifo();
   endtask

   task automatic push(input logic [BITSIZE-1:0] w);
      q.push_back(w);
      drive_fifo();
   endtask

   task automatic check_word_log(input string tag, input int first_cyc);
      chk({tag, "_nbeats"}, hs_log.size(), 4);
      for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
         chk({tag, "_beat"}, hs_log[i].d, lit[i]);
         chk({tag, "_lastflag"}, hs_log[i].last, (i == 3));
         if (first_cyc >= 0) chk({tag, "_beatcyc"}, hs_log[i].cyc, first_cyc + i);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [63:0] r;
      int pc;
`ifdef UNPACK_MSB_FIRST_EN
      lit = '{11'h7FF, 11'h001, 11'h155, 11'h2AA};
`else
      lit = '{11'h2AA, 11'h155, 11'h001, 11'h7FF};
`endif
      rstn = 1'b0; out_ready = 1'b0; fifo_emptyp = 1'b1; fifo_data = '0;
      repeat (3) tick();
      rstn = 1'b1;

      // Empty FIFO: nothing moves.
      for (int i = 0; i < 20; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         chk("empty_readp", fifo_readp, 0);
         chk("empty_valid", out_valid, 0);
         chk("empty_busy", busy, 0);
      end

      // Single word, ready held high.
      out_ready = 1'b1;
      hs_log.delete(); pop_log.delete();
      push(W1);
      pc = cyc + 1;
      repeat (6) tick();
      check_word_log("single", pc + 1);
      chk("single_pops", pop_log.size(), 1);
      chk("single_count", word_count, 1);
      chk("single_idle", busy, 0);

      // Three words back to back.
      hs_log.delete(); pop_log.delete();
      for (int i = 0; i < 3; i++) begin
         r = {$urandom(), $urandom()};
         q.push_back(r[BITSIZE-1:0]);
      end
      drive_fifo();
      repeat (14) tick();
      chk("b2b_pops", pop_log.size(), 3);
      if (pop_log.size() == 3) begin
         chk("b2b_pop1", pop_log[1] - pop_log[0], 4);
         chk("b2b_pop2", pop_log[2] - pop_log[0], 8);
         chk("b2b_nbeats", hs_log.size(), 12);
         for (int i = 0; i < hs_log.size(); i++) chk("b2b_nobubble", hs_log[i].cyc, pop_log[0] + 1 + i);
      end
      chk("b2b_count", word_count, 4);

      // Backpressure on beat 2.
      hs_log.delete(); pop_log.delete();
      push(W1);
      repeat (3) tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, lit[2]);
         chk("bp_readp", fifo_readp, 0);
         tick();
      end
      out_ready = 1'b1;
      repeat (4) tick();
      check_word_log("bp", -1);
      chk("bp_count", word_count, 5);

      // Reset during beat 1.
      push(44'h123_4567_89AB);
      repeat (2) tick();
      rstn = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", word_count, 0);
      tick();
      rstn = 1'b1;
      hs_log.delete(); pop_log.delete();
      push(W1);
      pc = cyc + 1;
      repeat (6) tick();
      check_word_log("after_rst", pc + 1);
      chk("after_rst_count", word_count, 1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         if (q.size() < 8 && $urandom_range(0, 2) == 0) begin
            r = {$urandom(), $urandom()};
            push(r[BITSIZE-1:0]);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
         end
         tick();
      end
      out_ready = 1'b1;
      repeat (60) tick();
      chk("drain_fifo_empty", q.size(), 0);
      chk("drain_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Drain-side companion to the team's 44-bit show-ahead FIFO. It pops one word at a time whenever the FIFO is non-empty and serializes each word into CHUNK-bit beats on a downstream valid/ready stream, flagging the last beat of each word. It sits directly on the FIFO read port: it drives readp and consumes data_out and emptyp.

## Interface
- BITSIZE, 44, FIFO word width; must be an integer multiple of CHUNK.
- CHUNK, 11, output beat width.
- BEATS, BITSIZE/CHUNK (derived, 4), beats per word.
- clk  input  1  rising-edge clock, shared with the FIFO.
- rstn  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- fifo_data  input  BITSIZE  FIFO head word, show-ahead; valid while fifo_emptyp=0.
- fifo_emptyp  input  1  FIFO empty flag.
- fifo_readp  output  1  combinational pop request; the FIFO advances tail at the next rising clk edge.
- out_data  output  CHUNK  current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  high with the final beat of a word.
- busy  output  1  high in SEND.
- word_count  output  16  count of fully transmitted words; wraps at 16'hFFFF to 0.

## Operation
- Two-state FSM: IDLE, SEND. Registers: shift register sreg[BITSIZE-1:0], beat_cnt[$clog2(BEATS)-1:0], word_count.
- IDLE: if fifo_emptyp=0, then fifo_readp=1, sreg<=fifo_data, beat_cnt<=0, go to SEND. Otherwise hold.
- SEND: out_valid=1; out_data=sreg[CHUNK-1:0]; out_last=(beat_cnt==BEATS-1).
- Handshake (out_valid&out_ready), beat_cnt<BEATS-1: sreg<=sreg>>CHUNK, beat_cnt<=beat_cnt+1.
- Handshake on the last beat: word_count<=word_count+1.
  - If fifo_emptyp=0, then fifo_readp=1, load the next word, beat_cnt<=0, stay in SEND. Back-to-back words have no bubble.
  - Otherwise go to IDLE.
- fifo_readp is only ever asserted while fifo_emptyp=0. Exactly one pop occurs per word.
- out_valid&!out_ready: out_data, out_last, sreg and beat_cnt hold; no pop.
- out_data is 0 whenever out_valid=0.

## Timing
- Reset (rstn low, async) values:
  - state=IDLE, sreg=0, beat_cnt=0, word_count=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - fifo_readp is forced to 0 while rstn=0.
- Latency:
  - fifo_emptyp falls in cycle N: pop at the end of N; out_valid=1 in N+1.
  - With out_ready held high, a word occupies exactly BEATS cycles.
- The fifo_readp path is combinational from fifo_emptyp, state and out_ready. The FIFO's emptyp is registered-count derived, so no loop exists.
- Reset mid-word: the partial word is discarded and the FIFO entry already popped is lost. word_count is not incremented.
- out_ready may toggle freely. The out_valid protocol never drops a beat: once asserted, out_valid stays high until accepted.

## Configuration
- UNPACK_MSB_FIRST_EN defined:
  - Beats are emitted MSB chunk first: out_data=sreg[BITSIZE-1 -: CHUNK], shift left.
  - out_last still marks the 4th beat.
- Undefined (default): LSB chunk first, as described above.

## Test plan
- Single word {11'h7FF,11'h001,11'h155,11'h2AA}, out_ready=1:
  - Beats 2AA,155,001,7FF in 4 consecutive cycles.
  - out_last only on 7FF.
  - One fifo_readp pulse; word_count=1; back to IDLE.
- Three words preloaded, out_ready=1:
  - 12 consecutive valid beats with no bubble.
  - fifo_readp high exactly on cycles 0,4,8; word_count=3.
- Backpressure: out_ready low for 5 cycles on beat 2:
  - out_data=11'h001 stable and out_valid=1 throughout; no pop.
  - Sequence resumes intact.
- Reset asserted during beat 1 of a word:
  - All outputs go to reset values immediately; word_count=0.
  - The next word after release streams from beat 0.
- Empty FIFO held for 20 cycles: fifo_readp, out_valid and busy stay 0.
- UNPACK_MSB_FIRST_EN build, same word as the first scenario: beats 7FF,001,155,2AA with out_last on 2AA.
